// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 pipeline EX stage: ALU ops, branch/M-ext funct3,
// forward-select codes and the mul/div FSM states.
package riscv_pkg;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_AND   = 4'h2;
   localparam logic [3:0] ALU_OR    = 4'h3;
   localparam logic [3:0] ALU_XOR   = 4'h4;
   localparam logic [3:0] ALU_SLT   = 4'h5;
   localparam logic [3:0] ALU_SLTU  = 4'h6;
   localparam logic [3:0] ALU_SLL   = 4'h7;
   localparam logic [3:0] ALU_SRL   = 4'h8;
   localparam logic [3:0] ALU_SRA   = 4'h9;
   localparam logic [3:0] ALU_PASSB = 4'hA;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic [31:0] neg_if(input logic i_neg, input logic [31:0] i_v);
      return i_neg ? (~i_v + 32'd1) : i_v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: one shift-add or restoring-subtract step per cycle on
// operand magnitudes, sign fix-up applied on the DONE cycle.
module muldiv_unit
   import riscv_pkg::*;
#(
   parameter int unsigned MD_ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result
);

   localparam logic [5:0] LAST_STEP = 6'(MD_ITER - 1);

   md_state_e   r_state, w_next;
   logic [5:0]  r_cnt;
   logic [2:0]  r_op;
   logic [31:0] r_a, r_hi, r_lo, r_mb;
   logic        r_neg_q, r_neg_r, r_b_zero;

   logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag;
   logic [32:0] w_madd, w_sh;
   logic [31:0] w_sub;
   logic        w_ge;
   logic [63:0] w_prod;

   assign w_a_signed = (i_op == MD_MULH) | (i_op == MD_MULHSU) | (i_op == MD_DIV) | (i_op == MD_REM);
   assign w_b_signed = (i_op == MD_MULH) | (i_op == MD_DIV) | (i_op == MD_REM);
   assign w_a_neg    = w_a_signed & i_a[31];
   assign w_b_neg    = w_b_signed & i_b[31];
   assign w_a_mag    = neg_if(w_a_neg, i_a);
   assign w_b_mag    = neg_if(w_b_neg, i_b);

   // r_hi:r_lo is the product accumulator for mul, remainder:quotient for div
   assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : 33'd0);
   assign w_sh   = {r_hi, r_lo[31]};
   assign w_ge   = w_sh >= {1'b0, r_mb};
   assign w_sub  = w_sh[31:0] - r_mb;

   always_comb begin
      w_next = r_state;
      case (r_state)
         MD_IDLE: if (i_start) w_next = MD_BUSY;
         MD_BUSY: if (r_cnt == LAST_STEP) w_next = MD_DONE;
         MD_DONE: w_next = MD_IDLE;
         default: w_next = MD_IDLE;
      endcase
      if (i_abort) w_next = MD_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= MD_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_mb     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_b_zero <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == MD_IDLE && i_start && !i_abort) begin
            r_cnt    <= '0;
            r_op     <= i_op;
            r_a      <= i_a;
            r_hi     <= '0;
            r_lo     <= w_a_mag;
            r_mb     <= w_b_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_b_zero <= (i_b == '0);
         end else if (r_state == MD_BUSY) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_op[2]) begin
               r_hi <= w_ge ? w_sub : w_sh[31:0];
               r_lo <= {r_lo[30:0], w_ge};
            end else begin
               r_hi <= w_madd[32:1];
               r_lo <= {w_madd[0], r_lo[31:1]};
            end
         end
      end
   end

   assign w_prod = r_neg_q ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};

   always_comb begin
      o_result = '0;
      case (r_op)
         MD_MUL:                      o_result = w_prod[31:0];
         MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[63:32];
         MD_DIV, MD_DIVU:             o_result = r_b_zero ? '1  : neg_if(r_neg_q, r_lo);
         default:                     o_result = r_b_zero ? r_a : neg_if(r_neg_r, r_hi);
      endcase
   end

   assign o_busy = (r_state == MD_BUSY);
   assign o_done = (r_state == MD_DONE);

endmodule

// File: rtl/execute_cycle.sv
// RV32 EX stage: forwarding, ALU, branch/jump resolve and EX/MEM register.
// Define EXEC_MULDIV_EN to add the iterative M-extension unit (stalls the pipe while busy).
module execute_cycle
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic [1:0]      ResultSrcE,
   input  logic            BranchE,
   input  logic            JumpE,
   input  logic            ALUSrcE,
   input  logic [3:0]      ALUControlE,
   input  logic [2:0]      BranchOpE,
   input  logic            MulDivE,
   input  logic [2:0]      MulDivOpE,
   input  logic            FlushE,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] RD1_E,
   input  logic [XLEN-1:0] RD2_E,
   input  logic [XLEN-1:0] Imm_Ext_E,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [4:0]      RD_E,
   input  logic [XLEN-1:0] ResultW,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [4:0]      RD_M,
   output logic [XLEN-1:0] PCPlus4M,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] ALU_ResultM,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            StallE
);

   logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu, w_ex_result;
   logic            w_cond;

   always_comb begin
      case (ForwardAE)
         FWD_W:   w_src_a = ResultW;
         FWD_M:   w_src_a = ALU_ResultM;
         default: w_src_a = RD1_E;
      endcase
      case (ForwardBE)
         FWD_W:   w_fwd_b = ResultW;
         FWD_M:   w_fwd_b = ALU_ResultM;
         default: w_fwd_b = RD2_E;
      endcase
   end

   assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

   always_comb begin
      w_alu = '0;
      case (ALUControlE)
         ALU_ADD:   w_alu = w_src_a + w_src_b;
         ALU_SUB:   w_alu = w_src_a - w_src_b;
         ALU_AND:   w_alu = w_src_a & w_src_b;
         ALU_OR:    w_alu = w_src_a | w_src_b;
         ALU_XOR:   w_alu = w_src_a ^ w_src_b;
         ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
         ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, w_src_a < w_src_b};
         ALU_SLL:   w_alu = w_src_a << w_src_b[4:0];
         ALU_SRL:   w_alu = w_src_a >> w_src_b[4:0];
         ALU_SRA:   w_alu = $signed(w_src_a) >>> w_src_b[4:0];
         ALU_PASSB: w_alu = w_src_b;
         default:   w_alu = '0;
      endcase
   end

   // Branches compare the forwarded register operands, never the immediate
   always_comb begin
      w_cond = 1'b0;
      case (BranchOpE)
         BR_EQ:   w_cond = (w_src_a == w_fwd_b);
         BR_NE:   w_cond = (w_src_a != w_fwd_b);
         BR_LT:   w_cond = ($signed(w_src_a) <  $signed(w_fwd_b));
         BR_GE:   w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
         BR_LTU:  w_cond = (w_src_a <  w_fwd_b);
         BR_GEU:  w_cond = (w_src_a >= w_fwd_b);
         default: w_cond = 1'b0;
      endcase
   end

   assign PCSrcE    = JumpE | (BranchE & w_cond);
   assign PCTargetE = (JumpE & ALUSrcE) ? {w_alu[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);

`ifdef EXEC_MULDIV_EN
   logic            w_md_start, w_md_busy, w_md_done;
   logic [XLEN-1:0] w_md_result;

   assign w_md_start = MulDivE & ~FlushE;

   muldiv_unit #(
      .MD_ITER (MD_ITER)
   ) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_md_start),
      .i_abort  (FlushE),
      .i_op     (MulDivOpE),
      .i_a      (w_src_a),
      .i_b      (w_fwd_b),
      .o_busy   (w_md_busy),
      .o_done   (w_md_done),
      .o_result (w_md_result)
   );

   // Issue cycle and every BUSY cycle stall; DONE releases the pipe with the result
   assign StallE      = ~FlushE & ((MulDivE & ~w_md_done) | w_md_busy);
   assign w_ex_result = w_md_done ? w_md_result : w_alu;
`else
   logic w_unused_md;
   assign w_unused_md = (^{MulDivE, MulDivOpE}) ^ MD_ITER[0];
   assign StallE      = 1'b0;
   assign w_ex_result = w_alu;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultSrcM  <= '0;
         RD_M        <= '0;
         PCPlus4M    <= '0;
         WriteDataM  <= '0;
         ALU_ResultM <= '0;
      end else if (FlushE || StallE) begin
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else begin
         RegWriteM   <= RegWriteE;
         MemWriteM   <= MemWriteE;
         ResultSrcM  <= ResultSrcE;
         RD_M        <= RD_E;
         PCPlus4M    <= PCPlus4E;
         WriteDataM  <= w_fwd_b;
         ALU_ResultM <= w_ex_result;
      end
   end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle; mul/div scenarios run only when EXEC_MULDIV_EN is defined.
module tb_execute_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, MulDivE, FlushE;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
   logic [3:0]  ALUControlE;
   logic [2:0]  BranchOpE, MulDivOpE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
   logic [4:0]  RD_E;
   logic        RegWriteM, MemWriteM, PCSrcE, StallE;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, PCTargetE;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   execute_cycle #(.XLEN(32), .MD_ITER(32)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .BranchOpE(BranchOpE), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RD1_E(RD1_E), .RD2_E(RD2_E),
      .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
      .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE)
   );

   task automatic idle_inputs();
      RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; JumpE = 0;
      ALUSrcE = 0; ALUControlE = 0; BranchOpE = 3'b010; MulDivE = 0; MulDivOpE = 0;
      FlushE = 0; ForwardAE = 0; ForwardBE = 0; RD1_E = 0; RD2_E = 0;
      Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0; ResultW = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      RegWriteE = 1; MemWriteE = 1; RD_E = 5'd7; PCPlus4E = 32'h44; RD1_E = 32'h9;
      @(posedge clk); #1;
      n_vec++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
         $display("FAIL reset_outputs: got RW=%b MW=%b RS=%h RD=%h PC4=%h WD=%h ALU=%h want all 0",
                  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM);
         n_err++;
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL reset_stall: got %b want 0", StallE); n_err++;
      end
   endtask

   task automatic test_forward_add();
      @(negedge clk);
      idle_inputs();
      RegWriteE = 1; ALUSrcE = 1; Imm_Ext_E = 32'd5; ALUControlE = 4'hA; RD_E = 5'd3;
      @(posedge clk); #1;
      n_vec++;
      if (ALU_ResultM !== 32'd5) begin
         $display("FAIL passb_seed: got %h want 00000005", ALU_ResultM); n_err++;
      end
      @(negedge clk);
      idle_inputs();
      RegWriteE = 1; RD1_E = 32'd7; RD2_E = 32'hFFFF_FFFF; ForwardAE = 2'b10;
      ALUControlE = 4'h0; RD_E = 5'd4; PCPlus4E = 32'h44;
      @(posedge clk); #1;
      n_vec++;
      if (ALU_ResultM !== 32'd4 || RegWriteM !== 1'b1) begin
         $display("FAIL fwdM_add: got alu=%h rw=%b want 00000004 1", ALU_ResultM, RegWriteM); n_err++;
      end
      n_vec++;
      if (RD_M !== 5'd4 || WriteDataM !== 32'hFFFF_FFFF || PCPlus4M !== 32'h44) begin
         $display("FAIL fwdM_fields: got rd=%h wd=%h pc4=%h want 04 ffffffff 00000044",
                  RD_M, WriteDataM, PCPlus4M); n_err++;
      end
   endtask

   task automatic test_forward_w();
      @(negedge clk);
      idle_inputs();
      MemWriteE = 1; ResultSrcE = 2'b01; RD1_E = 32'h3; RD2_E = 32'hDEAD;
      ForwardBE = 2'b01; ResultW = 32'h10; ALUControlE = 4'h1;
      @(posedge clk); #1;
      n_vec++;
      if (ALU_ResultM !== 32'hFFFF_FFF3 || WriteDataM !== 32'h10) begin
         $display("FAIL fwdW_sub: got alu=%h wd=%h want fffffff3 00000010", ALU_ResultM, WriteDataM);
         n_err++;
      end
      n_vec++;
      if (MemWriteM !== 1'b1 || RegWriteM !== 1'b0 || ResultSrcM !== 2'b01) begin
         $display("FAIL fwdW_ctrl: got mw=%b rw=%b rs=%b want 1 0 01", MemWriteM, RegWriteM, ResultSrcM);
         n_err++;
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0]  ops [11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF, 4'hB};
      logic [31:0] as  [11] = '{32'd5, 32'hF0F0, 32'hF0F0, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd1, 32'h80000000, 32'h80000000, 32'h12345678, 32'h12345678};
      logic [31:0] bs  [11] = '{32'd7, 32'hFF00, 32'h0F0F, 32'hFF00FF00, 32'd1, 32'd1,
                                32'h3F, 32'd4, 32'd4, 32'd1, 32'd1};
      logic [31:0] exp [11] = '{32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'h00FFFF00, 32'd1, 32'd0,
                                32'h80000000, 32'h08000000, 32'hF8000000, 32'd0, 32'd0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         idle_inputs();
         RegWriteE = 1; ALUControlE = ops[i]; RD1_E = as[i]; RD2_E = bs[i];
         @(posedge clk); #1;
         n_vec++;
         if (ALU_ResultM !== exp[i]) begin
            $display("FAIL alu_op_%h: got %h want %h", ops[i], ALU_ResultM, exp[i]); n_err++;
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0]  op  [8] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b100};
      logic [31:0] as  [8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd9, 32'd9, 32'hFFFFFFFE, 32'hFFFFFFFE,
                               32'd1, 32'hFFFFFFFE};
      logic [31:0] bs  [8] = '{32'd1, 32'd1, 32'd9, 32'd9, 32'd1, 32'd1, 32'd1, 32'd1};
      logic        br  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle_inputs();
         BranchE = br[i]; BranchOpE = op[i]; RD1_E = as[i]; RD2_E = bs[i];
         PCE = 32'h100; Imm_Ext_E = 32'h20;
         #1;
         n_vec++;
         if (PCSrcE !== exp[i] || PCTargetE !== 32'h120) begin
            $display("FAIL branch_%0d: got src=%b tgt=%h want %b 00000120", i, PCSrcE, PCTargetE, exp[i]);
            n_err++;
         end
      end
   endtask

   task automatic test_jump();
      @(negedge clk);
      idle_inputs();
      JumpE = 1; PCE = 32'h200; Imm_Ext_E = 32'h10; RD1_E = 32'h5555;
      #1;
      n_vec++;
      if (PCSrcE !== 1'b1 || PCTargetE !== 32'h210) begin
         $display("FAIL jal: got src=%b tgt=%h want 1 00000210", PCSrcE, PCTargetE); n_err++;
      end
      @(negedge clk);
      idle_inputs();
      JumpE = 1; ALUSrcE = 1; RD1_E = 32'h1001; Imm_Ext_E = 32'h4; PCE = 32'h200;
      PCPlus4E = 32'h204; RegWriteE = 1; ResultSrcE = 2'b10; RD_E = 5'd1;
      #1;
      n_vec++;
      if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1004) begin
         $display("FAIL jalr: got src=%b tgt=%h want 1 00001004", PCSrcE, PCTargetE); n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (PCPlus4M !== 32'h204 || ResultSrcM !== 2'b10 || RD_M !== 5'd1) begin
         $display("FAIL jalr_link: got pc4=%h rs=%b rd=%h want 00000204 10 01", PCPlus4M, ResultSrcM, RD_M);
         n_err++;
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      idle_inputs();
      FlushE = 1; RegWriteE = 1; MemWriteE = 1; RD1_E = 32'h1; RD2_E = 32'h2;
      #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL flush_stall: got %b want 0", StallE); n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
         $display("FAIL flush_bubble: got rw=%b mw=%b want 0 0", RegWriteM, MemWriteM); n_err++;
      end
   endtask

`ifndef EXEC_MULDIV_EN
   task automatic test_muldiv_ignored();
      @(negedge clk);
      idle_inputs();
      MulDivE = 1; MulDivOpE = 3'b100; RegWriteE = 1; RD1_E = 32'd2; RD2_E = 32'd3;
      #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL md_ignored_stall: got %b want 0", StallE); n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (ALU_ResultM !== 32'd5 || RegWriteM !== 1'b1) begin
         $display("FAIL md_ignored_add: got alu=%h rw=%b want 00000005 1", ALU_ResultM, RegWriteM);
         n_err++;
      end
   endtask
`else
   task automatic test_div_overflow();
      int stall_bad = 0;
      int rw_bad    = 0;
      @(negedge clk);
      idle_inputs();
      MulDivE = 1; MulDivOpE = 3'b100; RegWriteE = 1; RD_E = 5'd6;
      RD1_E = 32'h8000_0000; RD2_E = 32'hFFFF_FFFF;
      #1;
      for (int i = 0; i < 33; i++) begin
         if (StallE !== 1'b1) stall_bad++;
         @(posedge clk); #1;
         if (RegWriteM !== 1'b0) rw_bad++;
      end
      n_vec++;
      if (stall_bad != 0) begin
         $display("FAIL div_stall_len: got %0d low cycles want 0", stall_bad); n_err++;
      end
      n_vec++;
      if (rw_bad != 0) begin
         $display("FAIL div_stall_bubble: got %0d writes want 0", rw_bad); n_err++;
      end
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL div_done_stall: got %b want 0", StallE); n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (ALU_ResultM !== 32'h8000_0000 || RegWriteM !== 1'b1 || RD_M !== 5'd6) begin
         $display("FAIL div_overflow: got alu=%h rw=%b rd=%h want 80000000 1 06", ALU_ResultM, RegWriteM, RD_M);
         n_err++;
      end
   endtask

   task automatic test_muldiv_ops();
      logic [2:0]  op  [4] = '{3'b111, 3'b001, 3'b011, 3'b110};
      logic [31:0] as  [4] = '{32'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
      logic [31:0] bs  [4] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
      logic [31:0] exp [4] = '{32'd17, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFF};
      int          cyc;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle_inputs();
         MulDivE = 1; MulDivOpE = op[i]; RegWriteE = 1; RD1_E = as[i]; RD2_E = bs[i];
         @(posedge clk); #1;
         cyc = 0;
         while (StallE === 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
         end
         n_vec++;
         if (cyc != 32) begin
            $display("FAIL md_latency_%0d: got %0d busy cycles want 32", i, cyc); n_err++;
         end
         @(posedge clk); #1;
         n_vec++;
         if (ALU_ResultM !== exp[i]) begin
            $display("FAIL md_op_%0d: got %h want %h", i, ALU_ResultM, exp[i]); n_err++;
         end
      end
   endtask

   task automatic test_reset_in_busy();
      @(negedge clk);
      idle_inputs();
      MulDivE = 1; MulDivOpE = 3'b011; RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b01;
      RD_E = 5'd9; PCPlus4E = 32'h88; RD1_E = 32'd3; RD2_E = 32'd5;
      repeat (11) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      MulDivE = 0;
      @(posedge clk); #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL rst_busy_stall: got %b want 0", StallE); n_err++;
      end
      n_vec++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
         $display("FAIL rst_busy_outputs: got RW=%b MW=%b RS=%h RD=%h PC4=%h WD=%h ALU=%h want all 0",
                  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM);
         n_err++;
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      RegWriteE = 1; RD1_E = 32'd3; RD2_E = 32'd4; RD_E = 5'd5;
      #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL post_rst_stall: got %b want 0", StallE); n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (ALU_ResultM !== 32'd7 || RegWriteM !== 1'b1 || RD_M !== 5'd5) begin
         $display("FAIL post_rst_add: got alu=%h rw=%b rd=%h want 00000007 1 05", ALU_ResultM, RegWriteM, RD_M);
         n_err++;
      end
   endtask

   task automatic test_flush_busy();
      @(negedge clk);
      idle_inputs();
      MulDivE = 1; MulDivOpE = 3'b101; RegWriteE = 1; RD1_E = 32'd100; RD2_E = 32'd7;
      repeat (5) @(posedge clk);
      @(negedge clk);
      FlushE = 1;
      #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL flush_busy_stall: got %b want 0", StallE); n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (RegWriteM !== 1'b0) begin
         $display("FAIL flush_busy_bubble: got rw=%b want 0", RegWriteM); n_err++;
      end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (StallE !== 1'b0) begin
         $display("FAIL flush_busy_idle: got %b want 0", StallE); n_err++;
      end
   endtask
`endif

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_forward_add();
      test_forward_w();
      test_alu_ops();
      test_branch();
      test_jump();
      test_flush();
`ifndef EXEC_MULDIV_EN
      test_muldiv_ignored();
`else
      test_div_overflow();
      test_muldiv_ops();
      test_reset_in_busy();
      test_flush_busy();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
